// File: rtl/rv16_div_pkg.sv
// ============================================================================
// Module : rv16_div_pkg
// Brief  : Shared state encoding and latency constants for the rv16 divider.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rv16_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  localparam int DIV_LATENCY     = 18;
  localparam int SPECIAL_LATENCY = 1;

endpackage

`default_nettype wire

// File: rtl/rv16_sub_unit.sv
// ============================================================================
// Module : rv16_sub_unit
// Brief  : Combinational W-bit subtractor (a - b) with borrow-out.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv16_sub_unit #(
  parameter int W = 17
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_diff,
  output logic         o_borrow
);

  assign {o_borrow, o_diff} = {1'b0, i_a} - {1'b0, i_b};

endmodule

`default_nettype wire

// File: rtl/rv16_div_unit.sv
// ============================================================================
// Module : rv16_div_unit
// Brief  : Multi-cycle restoring divider, one quotient bit per cycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rv16_div_unit
  import rv16_div_pkg::*;
#(
  parameter int DATA = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic            div_signed,
  input  logic [DATA-1:0] rs1_div_in,
  input  logic [DATA-1:0] rs2_div_in,
  output logic [DATA-1:0] rd_quot_out,
  output logic [DATA-1:0] rd_rem_out,
  output logic            div_busy,
  output logic            div_done,
  output logic            div_by_zero
);

  localparam int              CNT_W = $clog2(DATA);
  localparam logic [DATA-1:0] c_ONE = DATA'(1);
  localparam logic [DATA-1:0] c_MIN = {1'b1, {(DATA-1){1'b0}}};

  div_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [DATA-1:0]  r_rem, r_dvd, r_dvs;
  logic             r_qneg, r_rneg;

  logic            w_a_neg, w_b_neg, w_div0, w_ovf, w_borrow, w_unused;
  logic [DATA-1:0] w_abs_a, w_abs_b, w_rem_nxt, w_q_nxt, w_q_fix, w_r_fix;
  logic [DATA:0]   w_shift, w_diff;

  assign w_a_neg = div_signed & rs1_div_in[DATA-1];
  assign w_b_neg = div_signed & rs2_div_in[DATA-1];
  assign w_abs_a = w_a_neg ? (~rs1_div_in + c_ONE) : rs1_div_in;
  assign w_abs_b = w_b_neg ? (~rs2_div_in + c_ONE) : rs2_div_in;
  assign w_div0  = (rs2_div_in == '0);
  assign w_ovf   = div_signed && (rs1_div_in == c_MIN) && (rs2_div_in == '1);

  // Dividend register doubles as the quotient: bits shift out of the top
  // into the remainder while quotient bits shift in at the bottom.
  assign w_shift = {r_rem, r_dvd[DATA-1]};

  rv16_sub_unit #(.W(DATA + 1)) u_trial_sub (
    .i_a      (w_shift),
    .i_b      ({1'b0, r_dvs}),
    .o_diff   (w_diff),
    .o_borrow (w_borrow)
  );

  // On success the difference is below the divisor, so its top bit is zero.
  assign w_unused  = w_diff[DATA];
  assign w_rem_nxt = w_borrow ? w_shift[DATA-1:0] : w_diff[DATA-1:0];
  assign w_q_nxt   = {r_dvd[DATA-2:0], ~w_borrow};
  assign w_q_fix   = r_qneg ? (~r_dvd + c_ONE) : r_dvd;
  assign w_r_fix   = r_rneg ? (~r_rem + c_ONE) : r_rem;

  assign div_busy = (r_state != IDLE);
  assign div_done = (r_state == DONE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (div_start) w_state_nxt = (w_div0 || w_ovf) ? DONE : CALC;
      CALC: if (r_cnt == CNT_W'(DATA - 1)) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      rd_quot_out <= '0;
      rd_rem_out  <= '0;
      div_by_zero <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (div_start) begin
            r_dvd  <= w_abs_a;
            r_dvs  <= w_abs_b;
            r_qneg <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (w_div0) begin
              rd_quot_out <= '1;
              rd_rem_out  <= rs1_div_in;
              div_by_zero <= 1'b1;
            end else if (w_ovf) begin
              rd_quot_out <= c_MIN;
              rd_rem_out  <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dvd <= w_q_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          rd_quot_out <= w_q_fix;
          rd_rem_out  <= w_r_fix;
          div_by_zero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv16_div_unit.sv
// ============================================================================
// Module : tb_rv16_div_unit
// Brief  : Directed self-checking bench for rv16_div_unit with a result queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rv16_div_unit;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        sgn = 1'b0;
  logic [15:0] rs1 = '0;
  logic [15:0] rs2 = '0;
  logic [15:0] quot, rem;
  logic        busy, done, dbz;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  rv16_div_unit #(.DATA(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_start   (div_start),
    .div_signed  (sgn),
    .rs1_div_in  (rs1),
    .rs2_div_in  (rs2),
    .rd_quot_out (quot),
    .rd_rem_out  (rem),
    .div_busy    (busy),
    .div_done    (done),
    .div_by_zero (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t e;
    if (b == 16'h0) begin
      e.q = 16'hFFFF; e.r = a; e.z = 1'b1; e.lat = 1;
    end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
      e.q = 16'h8000; e.r = 16'h0; e.z = 1'b0; e.lat = 1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b); e.z = 1'b0; e.lat = 18;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = 18;
    end
    return e;
  endfunction

  // Issues one request and follows it to div_done; optionally re-pulses
  // div_start mid-flight (repulse = cycle index) or asserts it during DONE.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input int repulse, input bit start_in_done);
    exp_t        e;
    logic [15:0] pq, pr;
    logic        pz;
    int          lat;
    bit          busy_ok, hold_ok;
    sb.push_back(model(a, b, s));
    pq = quot; pr = rem; pz = dbz;
    @(negedge clk);
    rs1 = a; rs2 = b; sgn = s; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0; rs1 = 16'($urandom); rs2 = 16'($urandom); sgn = 1'($urandom);
    lat = 1; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (quot !== pq || rem !== pr || dbz !== pz) hold_ok = 1'b0;
      if (lat == repulse) begin
        div_start = 1'b1; rs1 = 16'd9; rs2 = 16'd3; sgn = 1'b0;
      end
      @(posedge clk); #1;
      div_start = 1'b0;
      lat++;
    end
    e = sb.pop_front();
    check({tag, " latency"}, lat, e.lat);
    check({tag, " busy_during"}, busy_ok, 1'b1);
    check({tag, " hold_before_done"}, hold_ok, 1'b1);
    check({tag, " busy_in_done"}, busy, 1'b1);
    check({tag, " quot"}, quot, e.q);
    check({tag, " rem"}, rem, e.r);
    check({tag, " dbz"}, dbz, e.z);
    if (start_in_done) begin
      div_start = 1'b1; rs1 = 16'd9; rs2 = 16'd3; sgn = 1'b0;
    end
    @(posedge clk); #1;
    div_start = 1'b0;
    check({tag, " done_pulse_len"}, done, 1'b0);
    check({tag, " busy_after"}, busy, 1'b0);
    check({tag, " quot_held"}, quot, e.q);
  endtask

  initial begin
    int          extra_done;
    logic [15:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset quot", quot, 16'h0);
    check("reset rem", rem, 16'h0);
    check("reset dbz", dbz, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);

    run_op("u100_7",      16'd100,  16'd7,    1'b0, 0, 1'b0);
    run_op("s_m7_2",      16'hFFF9, 16'h0002, 1'b1, 0, 1'b0);
    run_op("s_7_m2",      16'h0007, 16'hFFFE, 1'b1, 0, 1'b1);
    run_op("s_div0",      16'h1234, 16'h0000, 1'b1, 0, 1'b0);
    run_op("u_div0",      16'h1234, 16'h0000, 1'b0, 0, 1'b1);
    run_op("s_ovf",       16'h8000, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op("u_8000_ffff", 16'h8000, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("u_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    run_op("s_m32768_3",  16'h8000, 16'h0003, 1'b1, 0, 1'b0);
    run_op("repulse",     16'd50,   16'd5,    1'b0, 5, 1'b0);

    // Mid-operation reset: the in-flight result must never appear.
    sb.push_back(model(16'd1000, 16'd3, 1'b0));
    @(negedge clk);
    rs1 = 16'd1000; rs2 = 16'd3; sgn = 1'b0; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort quot", quot, 16'h0);
    check("abort rem", rem, 16'h0);
    check("abort dbz", dbz, 1'b0);
    extra_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) extra_done++;
    end
    check("abort no_done", extra_done, 0);
    run_op("after_abort", 16'd9, 16'd3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom_range(1, 16'hFFFF));
      run_op("rand", ra, rb, 1'(i % 2), 0, 1'b0);
    end

    check("scoreboard empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
